// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter for the single regfile write port, plus a busy scoreboard for decode stalls.
// Define WB_RR_EN for round-robin arbitration; otherwise fixed priority with starvation promotion.
module regs_wb_arbiter #(
   parameter int unsigned NREQ       = 3,
   parameter int unsigned XLEN       = 64,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid_i,
   output logic [NREQ-1:0]      req_ready_o,
   input  logic [NREQ*5-1:0]    req_waddr_i,
   input  logic [NREQ*XLEN-1:0] req_wdata_i,
   output logic [4:0]           reg_waddr_o,
   output logic [XLEN-1:0]      reg_wdata_o,
   output logic                 reg_wen_o,
   input  logic                 issue_i,
   input  logic [4:0]           issue_rd_i,
   input  logic [4:0]           rs1_raddr_i,
   input  logic [4:0]           rs2_raddr_i,
   output logic                 hazard_o
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] valid_m;
   logic [NREQ-1:0] grant;
   logic            grant_any;
   logic [PW-1:0]   grant_idx;

   // No requester can be granted while reset is asserted.
   assign valid_m = rst ? req_valid_i : '0;

`ifdef WB_RR_EN
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         automatic int unsigned idx = (32'(rr_ptr_q) + k) % NREQ;
         if (!grant_any && valid_m[idx]) begin
            grant_any = 1'b1;
            grant_idx = PW'(idx);
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   localparam int unsigned CW = 4;

   logic [NREQ-1:0][CW-1:0] starve_q, starve_d;
   logic [NREQ-1:0]         promoted;

   always_comb begin
      promoted = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         promoted[i] = valid_m[i] && (starve_q[i] == CW'(STARVE_MAX));
      end
   end

   // A starved requester pre-empts plain priority; lowest index wins within each class.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!grant_any && promoted[i]) begin
            grant_any = 1'b1;
            grant_idx = PW'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!grant_any && valid_m[i]) begin
            grant_any = 1'b1;
            grant_idx = PW'(i);
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      starve_d = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (valid_m[i] && !grant[i]) begin
            starve_d[i] = (starve_q[i] == CW'(STARVE_MAX)) ? starve_q[i] : starve_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   assign req_ready_o = grant;

   logic [4:0]      sel_addr;
   logic [XLEN-1:0] sel_data;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_waddr_i[i*5 +: 5];
            sel_data = req_wdata_i[i*XLEN +: XLEN];
         end
      end
   end

   logic            wen_q, wen_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   // x0 writes are accepted but never enable the port.
   always_comb begin
      wen_d   = grant_any && (sel_addr != '0);
      waddr_d = grant_any ? sel_addr : waddr_q;
      wdata_d = grant_any ? sel_data : wdata_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign reg_wen_o   = wen_q;
   assign reg_waddr_o = waddr_q;
   assign reg_wdata_o = wdata_q;

   logic [31:0] busy_q, busy_d;

   // Set after clear so a new writer in flight keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (wen_q) begin
         busy_d[waddr_q] = 1'b0;
      end
      if (issue_i && (issue_rd_i != '0)) begin
         busy_d[issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   logic haz_rs1, haz_rs2;

   // The regfile bypasses the write on the port this cycle, so that register is not a hazard.
   always_comb begin
      haz_rs1 = (rs1_raddr_i != '0) && busy_q[rs1_raddr_i] && !(wen_q && (waddr_q == rs1_raddr_i));
      haz_rs2 = (rs2_raddr_i != '0) && busy_q[rs2_raddr_i] && !(wen_q && (waddr_q == rs2_raddr_i));
   end

   assign hazard_o = haz_rs1 || haz_rs2;

endmodule
